// File: rtl/SAL_AXI_RESP_PKG.sv
// Shared definitions for the AXI scratchpad responder: bus widths, burst encodings, response codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package SAL_AXI_RESP_PKG;

    localparam int AXI_DATA_WIDTH = 128;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_LEN_WIDTH  = 8;

    localparam logic [2:0] AXI_SIZE_128   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Response decided once at address acceptance. The burst end is computed
    // in 34 bits so a burst near the top of the 32-bit space cannot wrap and
    // look in-range. Out-of-range outranks an unsupported size/burst type.
    function automatic logic [1:0] addr_check(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [AXI_LEN_WIDTH-1:0]  len,
        input logic [2:0]                size,
        input logic [1:0]                burst,
        input logic [33:0]               mem_bytes
    );
        logic [33:0] end_byte;
        end_byte = {2'b00, addr & 32'hFFFF_FFF0} + ({26'd0, len} + 34'd1) * 34'd16;
        if (end_byte > mem_bytes)
            return RESP_DECERR;
        if (size != AXI_SIZE_128 || burst != AXI_BURST_INCR)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/AXI_A_IF.sv
// AXI address channel bundle (shared by AW and AR).
// Latency: n/a (wires only).
// Backpressure: valid/ready; the slave drives ready.
interface AXI_A_IF;
    import SAL_AXI_RESP_PKG::*;

    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]  len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      valid;
    logic                      ready;

    modport master (output id, addr, len, size, burst, valid, input ready);
    modport slave  (input id, addr, len, size, burst, valid, output ready);
endinterface

// File: rtl/AXI_B_IF.sv
// AXI write response channel bundle.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the master drives ready.
interface AXI_B_IF;
    import SAL_AXI_RESP_PKG::*;

    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
    logic                    valid;
    logic                    ready;

    modport master (input id, resp, valid, output ready);
    modport slave  (output id, resp, valid, input ready);
endinterface

// File: rtl/AXI_R_IF.sv
// AXI read data channel bundle.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the master drives ready.
interface AXI_R_IF;
    import SAL_AXI_RESP_PKG::*;

    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
    logic                      valid;
    logic                      ready;

    modport master (input id, data, resp, last, valid, output ready);
    modport slave  (output id, data, resp, last, valid, input ready);
endinterface

// File: rtl/AXI_W_IF.sv
// AXI write data channel bundle.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the slave drives ready.
interface AXI_W_IF;
    import SAL_AXI_RESP_PKG::*;

    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
    logic                      last;
    logic                      valid;
    logic                      ready;

    modport master (output data, strb, last, valid, input ready);
    modport slave  (input data, strb, last, valid, output ready);
endinterface

// File: rtl/sal_axi_resp_mem.sv
// Scratchpad storage: DEPTH x 128-bit flops, one byte-enabled write port, one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational (returns pre-write data in the write cycle).
// Backpressure: none; always accepts.
// Ports: clk; we/waddr/wstrb/wdata write port; raddr -> rdata read port. Contents are never reset.
module sal_axi_resp_mem #(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [15:0]                wstrb,
    input  logic [127:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [127:0]               rdata
);

    logic [127:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 16; b++) begin
                if (wstrb[b])
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sal_axi_sram_resp.sv
// AXI4 burst responder backed by an on-chip scratchpad; independent read and write paths, one burst each.
// Latency: AW->first wready 1 cycle, last W->bvalid 1 cycle, AR->first rvalid 1 cycle, R beats back-to-back.
// Backpressure: R and B outputs hold stable until ready; a new address is accepted only when its path is idle.
// Ports: clk, rst_n (async active-low); AW/W/B/AR/R slave modports.
module sal_axi_sram_resp #(
    parameter int DEPTH = 64
) (
    input  logic     clk,
    input  logic     rst_n,
    AXI_A_IF.slave   axi_aw_if,
    AXI_W_IF.slave   axi_w_if,
    AXI_B_IF.slave   axi_b_if,
    AXI_A_IF.slave   axi_ar_if,
    AXI_R_IF.slave   axi_r_if
);
    import SAL_AXI_RESP_PKG::*;

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [33:0] MEM_BYTES = 34'(DEPTH) * 34'd16;

    // Holds address ready low while reset is asserted; rises on the first
    // clock edge after release.
    logic rst_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    // ---------------- write path ----------------
    logic [1:0]              w_state;
    logic [AW-1:0]           w_idx;
    logic [7:0]              w_len;
    logic [7:0]              w_cnt;
    logic                    w_sup;
    logic [AXI_ID_WIDTH-1:0] w_id;
    logic [1:0]              w_resp;
    logic [1:0]              aw_chk;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    w_final;

    assign aw_chk  = addr_check(axi_aw_if.addr, axi_aw_if.len, axi_aw_if.size,
                                axi_aw_if.burst, MEM_BYTES);
    assign aw_hs   = axi_aw_if.valid && axi_aw_if.ready;
    assign w_hs    = (w_state == W_DATA) && axi_w_if.valid;
    // Burst length comes from the latched len, never from wlast.
    assign w_final = (w_cnt == w_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_sup   <= 1'b0;
            w_id    <= '0;
            w_resp  <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_idx   <= axi_aw_if.addr[AW+3:4];
                        w_len   <= axi_aw_if.len;
                        w_cnt   <= '0;
                        w_sup   <= (aw_chk != RESP_OKAY);
                        w_id    <= axi_aw_if.id;
                        w_resp  <= aw_chk;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        // A misplaced wlast downgrades the response but does
                        // not stop the data from being written.
                        if (w_resp != RESP_DECERR && axi_w_if.last != w_final)
                            w_resp <= RESP_SLVERR;
                        w_idx <= w_idx + AW'(1);
                        if (w_final) begin
                            w_cnt   <= '0;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_b_if.ready)
                        w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign axi_aw_if.ready = rst_done && (w_state == W_IDLE);
    assign axi_w_if.ready  = (w_state == W_DATA);
    assign axi_b_if.valid  = (w_state == W_RESP);
    assign axi_b_if.id     = w_id;
    assign axi_b_if.resp   = w_resp;

    // ---------------- read path ----------------
    logic [0:0]                r_state;
    logic [AW-1:0]             r_idx;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic                      r_sup;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                ar_chk;
    logic                      ar_hs;
    logic                      r_hs;
    logic [AW-1:0]             mem_raddr;
    logic [AXI_DATA_WIDTH-1:0] mem_rdata;

    assign ar_chk = addr_check(axi_ar_if.addr, axi_ar_if.len, axi_ar_if.size,
                               axi_ar_if.burst, MEM_BYTES);
    assign ar_hs  = axi_ar_if.valid && axi_ar_if.ready;
    assign r_hs   = (r_state == R_DATA) && axi_r_if.ready;

    // Each beat's data is registered one edge ahead: the first word at AR
    // acceptance, the next word whenever the current beat is taken. Sampling
    // the memory on the same edge as a write gives the pre-write contents.
    assign mem_raddr = (r_state == R_IDLE) ? axi_ar_if.addr[AW+3:4] : r_idx + AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_sup   <= 1'b0;
            r_id    <= '0;
            r_resp  <= RESP_OKAY;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_idx   <= axi_ar_if.addr[AW+3:4];
                        r_len   <= axi_ar_if.len;
                        r_cnt   <= '0;
                        r_sup   <= (ar_chk != RESP_OKAY);
                        r_id    <= axi_ar_if.id;
                        r_resp  <= ar_chk;
                        r_last  <= (axi_ar_if.len == 8'd0);
                        r_data  <= (ar_chk == RESP_OKAY) ? mem_rdata : '0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (r_last) begin
                            r_last  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt  <= r_cnt + 8'd1;
                            r_idx  <= r_idx + AW'(1);
                            r_last <= ((r_cnt + 8'd1) == r_len);
                            r_data <= r_sup ? '0 : mem_rdata;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign axi_ar_if.ready = rst_done && (r_state == R_IDLE);
    assign axi_r_if.valid  = (r_state == R_DATA);
    assign axi_r_if.id     = r_id;
    assign axi_r_if.data   = r_data;
    assign axi_r_if.resp   = r_resp;
    assign axi_r_if.last   = r_last;

    // ---------------- storage ----------------
    sal_axi_resp_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (w_hs && !w_sup),
        .waddr (w_idx),
        .wstrb (axi_w_if.strb),
        .wdata (axi_w_if.data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

endmodule
